// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: CPU has priority,
// a bounded starvation counter guarantees VID service, and read data is steered back.
module mem_port_arbiter #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StCpuRd, StCpuWr, StVidRd} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

    // Arbitration and RAM-side muxing; grants are masked while reset is asserted.
    always_comb begin
        cpu_gnt   = 1'b0;
        vid_gnt   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (vid_req && (!cpu_req || starve_q == StarveMax)) begin
                vid_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        mem_en = cpu_gnt | vid_gnt;
        mem_we = cpu_gnt & cpu_we;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (vid_gnt) begin
            mem_addr = vid_addr;
        end
    end

    always_comb begin
        state_d = StIdle;
        if (cpu_gnt) begin
            state_d = cpu_we ? StCpuWr : StCpuRd;
        end else if (vid_gnt) begin
            state_d = StVidRd;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!vid_req || vid_gnt) begin
            starve_d = '0;
        end else if (cpu_gnt && starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State holds last cycle's owner, so it marks which requester mem_rdata belongs to.
    always_comb begin
        cpu_rvalid  = (state_q == StCpuRd);
        vid_rvalid  = (state_q == StVidRd);
        cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        vid_rdata_d = vid_rvalid ? mem_rdata : vid_rdata_q;
        cpu_rdata   = cpu_rdata_d;
        vid_rdata   = vid_rdata_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

endmodule
